// File: rtl/guess_input_capture.sv
// guess_input_capture: player input front-end for the Bulls & Cows board.
// Synchronizes the switches and confirm button, debounces the button, captures
// one 4-digit guess per press, validates it and offers it over valid/ready.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// IDLE         | waiting for a press event; captures synced sw on press
// CHECK        | one cycle to validate the captured guess
// HOLD         | guess_valid high, guess frozen until the consumer accepts
// WAIT_RELEASE | transaction done; waits for btn_level=0 before re-arming
module guess_input_capture #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int SYNC_STAGES     = 2,
    parameter bit CHECK_DECIMAL   = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] sw,
    input  logic        btn,
    output logic [15:0] guess,
    output logic        guess_valid,
    input  logic        guess_ready,
    output logic        guess_error,
    output logic        btn_level
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        CHECK        = 2'd1,
        HOLD         = 2'd2,
        WAIT_RELEASE = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0]       btn_sync;
    logic [SYNC_STAGES-1:0][15:0] sw_sync;
    logic                         btn_s;
    logic [15:0]                  sw_s;
    logic [CNT_W-1:0]             db_cnt;
    logic                         btn_level_q;
    logic                         press;
    logic [3:0]                   d0, d1, d2, d3;
    logic                         guess_ok;
    logic                         capture;
    logic                         error_set;

    // Synchronizer chains for the raw button and all switch bits.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            btn_sync <= '0;
            sw_sync  <= '0;
        end else begin
            btn_sync <= {btn_sync[SYNC_STAGES-2:0], btn};
            sw_sync  <= {sw_sync[SYNC_STAGES-2:0], sw};
        end
    end

    assign btn_s = btn_sync[SYNC_STAGES-1];
    assign sw_s  = sw_sync[SYNC_STAGES-1];

    // Debounce: the level flips on the sample after the count of consecutive
    // differing samples has reached DEBOUNCE_CYCLES; any agreeing sample clears it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            db_cnt    <= '0;
            btn_level <= 1'b0;
        end else if (btn_s == btn_level) begin
            db_cnt <= '0;
        end else if (db_cnt == CNT_MAX) begin
            db_cnt    <= '0;
            btn_level <= ~btn_level;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    // Delayed debounced level for rising-edge (press) detection.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            btn_level_q <= 1'b0;
        end else begin
            btn_level_q <= btn_level;
        end
    end

    assign press = btn_level & ~btn_level_q;

    assign d0 = guess[15:12];
    assign d1 = guess[11:8];
    assign d2 = guess[7:4];
    assign d3 = guess[3:0];

    // Guess validation: digits pairwise distinct, optionally decimal only.
    always_comb begin
        guess_ok = (d0 != d1) && (d0 != d2) && (d0 != d3) &&
                   (d1 != d2) && (d1 != d3) && (d2 != d3);
        if (CHECK_DECIMAL && ((d0 > 4'd9) || (d1 > 4'd9) || (d2 > 4'd9) || (d3 > 4'd9))) begin
            guess_ok = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (press) begin
                    state_nxt = CHECK;
                end
            end
            CHECK: begin
                state_nxt = guess_ok ? HOLD : WAIT_RELEASE;
            end
            HOLD: begin
                if (guess_ready) begin
                    state_nxt = WAIT_RELEASE;
                end
            end
            WAIT_RELEASE: begin
                if (!btn_level) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: valid while holding, capture strobe, rejection strobe.
    always_comb begin
        guess_valid = (state == HOLD);
        capture     = (state == IDLE) && press;
        error_set   = (state == CHECK) && !guess_ok;
    end

    // Guess register: loaded only at the press event, frozen otherwise.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            guess <= '0;
        end else if (capture) begin
            guess <= sw_s;
        end
    end

    // Rejection pulse registered so it lines up with where guess_valid would rise.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            guess_error <= 1'b0;
        end else begin
            guess_error <= error_set;
        end
    end

endmodule

// File: tb/tb_guess_input_capture.sv
// Bench for guess_input_capture: two instances (decimal check on/off) share
// stimulus; a history-based reference model is checked every cycle, plus a
// vector table and directed sequences for reset, bounce and backpressure.
module tb_guess_input_capture;

    localparam int D  = 4;
    localparam int S  = 2;
    localparam int HN = 64;

    typedef struct {
        logic [15:0] sw;
        bit          ok_dec;
        bit          ok_hex;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] sw = '0;
    logic        btn = 1'b0;
    logic        guess_ready = 1'b0;
    logic [15:0] guess_d, guess_h;
    logic        valid_d, valid_h, err_d, err_h, lvl_d, lvl_h;

    always #5 clock = ~clock;

    guess_input_capture #(.DEBOUNCE_CYCLES(D), .SYNC_STAGES(S), .CHECK_DECIMAL(1'b1)) dut_dec (
        .clock(clock), .reset(reset), .sw(sw), .btn(btn),
        .guess(guess_d), .guess_valid(valid_d), .guess_ready(guess_ready),
        .guess_error(err_d), .btn_level(lvl_d)
    );

    guess_input_capture #(.DEBOUNCE_CYCLES(D), .SYNC_STAGES(S), .CHECK_DECIMAL(1'b0)) dut_hex (
        .clock(clock), .reset(reset), .sw(sw), .btn(btn),
        .guess(guess_h), .guess_valid(valid_h), .guess_ready(guess_ready),
        .guess_error(err_h), .btn_level(lvl_h)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: raw input history per edge, debounced level per edge,
    // and one transaction record per variant (0 = decimal, 1 = hex).
    int          edge_n = -1;
    int          last_rst_edge = -1;
    logic        hist_btn [HN];
    logic [15:0] hist_sw  [HN];
    logic        hist_lv  [HN];
    bit          m_open     [2];
    bit          m_valid    [2];
    bit          m_wait     [2];
    int          m_err_edge [2];
    logic [15:0] m_guess    [2];

    int          obs_rise, obs_fall, obs_vd, obs_ed, obs_vh, obs_eh;
    logic [15:0] obs_guess;
    logic        obs_prev_lvl;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, edge_n);
    endtask

    function automatic logic hb(int i);
        return (i <= last_rst_edge) ? 1'b0 : hist_btn[i % HN];
    endfunction

    function automatic logic [15:0] hsw(int i);
        return (i <= last_rst_edge) ? 16'h0 : hist_sw[i % HN];
    endfunction

    function automatic logic hlv(int i);
        return (i <= last_rst_edge) ? 1'b0 : hist_lv[i % HN];
    endfunction

    function automatic bit legal(logic [15:0] g, bit dec);
        logic [3:0] d [4];
        bit ok;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) d[i] = g[15-4*i -: 4];
        for (int i = 0; i < 4; i++)
            for (int j = i + 1; j < 4; j++)
                if (d[i] == d[j]) ok = 1'b0;
        if (dec)
            for (int i = 0; i < 4; i++)
                if (d[i] > 4'd9) ok = 1'b0;
        return ok;
    endfunction

    task automatic model_clear();
        for (int v = 0; v < 2; v++) begin
            m_open[v]     = 1'b0;
            m_valid[v]    = 1'b0;
            m_wait[v]     = 1'b0;
            m_err_edge[v] = -1;
            m_guess[v]    = '0;
        end
    endtask

    task automatic model_edge();
        int   t;
        logic prev;
        bit   all_diff;
        bit   press;
        edge_n++;
        t = edge_n;
        if (reset) begin
            last_rst_edge = t;
            model_clear();
            return;
        end
        hist_btn[t % HN] = btn;
        hist_sw[t % HN]  = sw;
        // level flips once the synced button has disagreed with it for D+1 samples
        prev = hlv(t - 1);
        all_diff = 1'b1;
        for (int k = 0; k <= D; k++)
            if (hb(t - S - k) == prev) all_diff = 1'b0;
        hist_lv[t % HN] = all_diff ? ~prev : prev;
        press = hlv(t - 1) && !hlv(t - 2);
        for (int v = 0; v < 2; v++) begin
            if (!m_open[v] && !m_wait[v]) begin
                if (press) begin
                    m_open[v]  = 1'b1;
                    m_guess[v] = hsw(t - S);
                end
            end else if (m_open[v] && !m_valid[v]) begin
                if (legal(m_guess[v], v == 0)) begin
                    m_valid[v] = 1'b1;
                end else begin
                    m_open[v]     = 1'b0;
                    m_wait[v]     = 1'b1;
                    m_err_edge[v] = t;
                end
            end else if (m_open[v]) begin
                if (guess_ready) begin
                    m_open[v]  = 1'b0;
                    m_valid[v] = 1'b0;
                    m_wait[v]  = 1'b1;
                end
            end else if (!hlv(t - 1)) begin
                m_wait[v] = 1'b0;
            end
        end
    endtask

    task automatic compare_all();
        chk("guess_dec", guess_d, m_guess[0]);
        chk("valid_dec", valid_d, m_valid[0]);
        chk("error_dec", err_d, m_err_edge[0] == edge_n);
        chk("level_dec", lvl_d, hlv(edge_n));
        chk("guess_hex", guess_h, m_guess[1]);
        chk("valid_hex", valid_h, m_valid[1]);
        chk("error_hex", err_h, m_err_edge[1] == edge_n);
        chk("level_hex", lvl_h, hlv(edge_n));
    endtask

    task automatic obs_clear();
        obs_rise = 0; obs_fall = 0; obs_vd = 0; obs_ed = 0; obs_vh = 0; obs_eh = 0;
        obs_guess = '0;
        obs_prev_lvl = lvl_d;
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        compare_all();
        if (lvl_d && !obs_prev_lvl) obs_rise++;
        if (!lvl_d && obs_prev_lvl) obs_fall++;
        obs_prev_lvl = lvl_d;
        if (valid_d) begin obs_vd++; obs_guess = guess_d; end
        if (err_d) obs_ed++;
        if (valid_h) obs_vh++;
        if (err_h) obs_eh++;
    endtask

    function automatic logic [15:0] rand_sw();
        if ($urandom_range(0, 1) == 1) return 16'($urandom);
        return {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs [8];
        int   e0;
        bit   found;
        int   seg;

        vecs[0] = '{16'h1234, 1'b1, 1'b1};
        vecs[1] = '{16'h1123, 1'b0, 1'b0};
        vecs[2] = '{16'h12A4, 1'b0, 1'b1};
        vecs[3] = '{16'h9876, 1'b1, 1'b1};
        vecs[4] = '{16'h0123, 1'b1, 1'b1};
        vecs[5] = '{16'hFEDC, 1'b0, 1'b1};
        vecs[6] = '{16'h0000, 1'b0, 1'b0};
        vecs[7] = '{16'h5A5B, 1'b0, 1'b0};

        model_clear();
        obs_clear();
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        repeat (5) step();

        // Vector table: clean press with ready high, latency and verdict per variant.
        for (int i = 0; i < 8; i++) begin
            btn = 1'b0;
            repeat (12) step();
            sw = vecs[i].sw;
            guess_ready = 1'b1;
            btn = 1'b1;
            e0 = edge_n + 1;
            found = 1'b0;
            for (int k = 0; k < 40 && !found; k++) begin
                step();
                if (valid_d || err_d) found = 1'b1;
            end
            chk("tbl_resolved", found, 1);
            if (found) begin
                chk("tbl_latency", edge_n - e0, S + D + 2);
                chk("tbl_valid_dec", valid_d, vecs[i].ok_dec);
                chk("tbl_error_dec", err_d, !vecs[i].ok_dec);
                chk("tbl_valid_hex", valid_h, vecs[i].ok_hex);
                chk("tbl_error_hex", err_h, !vecs[i].ok_hex);
                chk("tbl_guess_dec", guess_d, vecs[i].sw);
                chk("tbl_guess_hex", guess_h, vecs[i].sw);
            end
            step();
            chk("tbl_one_cycle_dec", valid_d | err_d, 0);
            chk("tbl_one_cycle_hex", valid_h | err_h, 0);
            obs_clear();
            repeat (50) step();
            chk("tbl_no_second", obs_vd + obs_ed + obs_vh + obs_eh, 0);
            chk("tbl_level_held", lvl_d, 1);
        end

        // Asynchronous reset in the middle of HOLD.
        btn = 1'b0;
        repeat (12) step();
        sw = 16'h1234;
        guess_ready = 1'b0;
        btn = 1'b1;
        repeat (10) step();
        chk("rst_pre_valid", valid_d, 1);
        chk("rst_pre_guess", guess_d, 16'h1234);
        #2 reset = 1'b1;
        #1;
        chk("rst_valid_dec", valid_d, 0);
        chk("rst_guess_dec", guess_d, 0);
        chk("rst_level_dec", lvl_d, 0);
        chk("rst_error_dec", err_d, 0);
        chk("rst_valid_hex", valid_h, 0);
        chk("rst_guess_hex", guess_h, 0);
        model_edge_async: begin
            last_rst_edge = edge_n;
            model_clear();
        end
        btn = 1'b0;
        repeat (2) step();
        reset = 1'b0;
        obs_clear();
        repeat (6) step();
        chk("rst_quiet", obs_vd + obs_ed, 0);
        guess_ready = 1'b1;
        btn = 1'b1;
        obs_clear();
        repeat (14) step();
        chk("rst_restart_count", obs_vd, 1);
        chk("rst_restart_guess", obs_guess, 16'h1234);

        // Bouncing press and bouncing release.
        btn = 1'b0;
        repeat (12) step();
        sw = 16'h9876;
        obs_clear();
        for (int i = 0; i < 20; i++) begin
            btn = ((i / 2) % 2 == 0);
            step();
        end
        btn = 1'b1;
        repeat (20) step();
        chk("bounce_rises", obs_rise, 1);
        chk("bounce_valids", obs_vd, 1);
        chk("bounce_guess", obs_guess, 16'h9876);
        obs_clear();
        for (int i = 0; i < 20; i++) begin
            btn = ((i / 2) % 2 == 1);
            step();
        end
        btn = 1'b0;
        repeat (20) step();
        chk("release_rises", obs_rise, 0);
        chk("release_falls", obs_fall, 1);
        chk("release_events", obs_vd + obs_ed, 0);

        // Backpressure: switches and button activity ignored while holding.
        sw = 16'h0123;
        guess_ready = 1'b0;
        btn = 1'b1;
        repeat (12) step();
        chk("bp_valid_start", valid_d, 1);
        sw = 16'h5678;
        btn = 1'b0;
        repeat (10) step();
        btn = 1'b1;
        repeat (10) step();
        chk("bp_guess_dec", guess_d, 16'h0123);
        chk("bp_guess_hex", guess_h, 16'h0123);
        chk("bp_valid_held", valid_d, 1);
        guess_ready = 1'b1;
        step();
        chk("bp_accepted", valid_d, 0);
        obs_clear();
        repeat (15) step();
        chk("bp_no_recapture", obs_vd + obs_ed, 0);
        btn = 1'b0;
        repeat (12) step();
        btn = 1'b1;
        obs_clear();
        repeat (12) step();
        chk("bp_next_count", obs_vd, 1);
        chk("bp_next_guess", obs_guess, 16'h5678);

        // Randomized traffic checked against the model every cycle.
        seg = 0;
        for (int c = 0; c < 3000; c++) begin
            if (seg == 0) begin
                btn = 1'($urandom_range(0, 1));
                seg = $urandom_range(1, 14);
            end
            seg--;
            if ($urandom_range(0, 15) == 0) sw = rand_sw();
            guess_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
